// File: rtl/fir_filter_mac.sv
// fir_filter_mac: time-multiplexed unsigned FIR filter.
// Accepts one sample at a time over a valid/ready handshake. A single shared
// multiply-accumulate stage walks the taps, one tap per clock, and the result
// is clamped to OUT_W bits. Coefficients can be rewritten at runtime while idle.
module fir_filter_mac #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 18,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  y,
    output logic              out_valid,
    output logic              sat,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_err
);

    // The accumulator is wide enough for TAPS full-scale products, so it never wraps.
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MAC  = 1'b1;

    logic [0:0]        r_state;
    logic [AW-1:0]     r_idx;
    logic [DATA_W-1:0] r_d [TAPS];
    logic [COEF_W-1:0] r_h [TAPS];
    logic [ACC_W-1:0]  r_acc;
    logic [OUT_W-1:0]  r_y;
    logic              r_sat;
    logic              r_out_valid;
    logic              r_coef_err;

    logic              w_accept;
    logic              w_addr_ok;
    logic              w_coef_wr;
    logic              w_last;
    logic [COEF_W-1:0] w_h_sel;
    logic [DATA_W-1:0] w_d_sel;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_full;
    logic [OUT_W:0]    w_clip;

    // Clamp an accumulator value to OUT_W bits; the MSB of the result flags clamping.
    function automatic logic [OUT_W:0] sat_clip(input logic [ACC_W-1:0] v);
        logic [CMP_W-1:0] wide;
        logic [CMP_W-1:0] lim;
        wide = CMP_W'(v);
        lim  = CMP_W'({OUT_W{1'b1}});
        if (wide > lim) begin
            return {1'b1, {OUT_W{1'b1}}};
        end
        return {1'b0, OUT_W'(wide)};
    endfunction

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept  = in_ready && in_valid;
    assign w_addr_ok = (int'(coef_addr) < TAPS);
    // Coefficients are frozen while a computation is in flight.
    assign w_coef_wr = coef_we && (r_state == S_IDLE) && w_addr_ok;
    assign w_last    = (r_idx == LAST_IDX);

    // Select the coefficient and delay-line entry for the current tap.
    always_comb begin
        w_h_sel = '0;
        w_d_sel = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (int'(r_idx) == k) begin
                w_h_sel = r_h[k];
                w_d_sel = r_d[k];
            end
        end
    end

    assign w_prod = PROD_W'(w_h_sel) * PROD_W'(w_d_sel);
    assign w_full = r_acc + ACC_W'(w_prod);
    assign w_clip = sat_clip(w_full);

    // Sequencer: wait for a sample, then step one tap per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_MAC;
                        r_idx   <= '0;
                    end
                end
                S_MAC: begin
                    r_idx <= r_idx + AW'(1);
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Delay line: newest sample in d[0], shifted only when a sample is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_d[k] <= '0;
            end
        end else if (w_accept) begin
            r_d[0] <= x;
            for (int k = 1; k < TAPS; k++) begin
                r_d[k] <= r_d[k-1];
            end
        end
    end

    // Coefficient bank: unity taps after reset give a moving sum until loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_h[k] <= COEF_W'(1);
            end
        end else if (w_coef_wr) begin
            for (int k = 0; k < TAPS; k++) begin
                if (int'(coef_addr) == k) begin
                    r_h[k] <= coef_data;
                end
            end
        end
    end

    // Accumulator: cleared on accept, adds one tap product per MAC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_state == S_MAC) begin
            r_acc <= w_full;
        end
    end

    // Result register: y/sat hold until the next result, out_valid pulses once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y         <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if ((r_state == S_MAC) && w_last) begin
                r_y         <= w_clip[OUT_W-1:0];
                r_sat       <= w_clip[OUT_W];
                r_out_valid <= 1'b1;
            end
        end
    end

    // Rejected coefficient writes (busy or out-of-range address) pulse coef_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coef_err <= 1'b0;
        end else begin
            r_coef_err <= coef_we && !((r_state == S_IDLE) && w_addr_ok);
        end
    end

    assign y         = r_y;
    assign sat       = r_sat;
    assign out_valid = r_out_valid;
    assign coef_err  = r_coef_err;

endmodule

// File: tb/tb_fir_filter_mac.sv
// tb_fir_filter_mac: directed scenarios plus randomized traffic for
// fir_filter_mac, checked every cycle against a sample-level reference model.
module tb_fir_filter_mac;

    localparam int TAPS   = 4;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 12;
    localparam int AW     = 3;
    localparam longint YMAX = (longint'(1) << OUT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] x;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  y;
    logic              out_valid;
    logic              sat;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_err;

    fir_filter_mac #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .sat(sat), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: sample history, coefficient table, and a countdown of
    // cycles until the pending result is due.
    longint m_hist [TAPS];
    longint m_h    [TAPS];
    int     m_busy    = 0;
    longint m_res_y   = 0;
    logic   m_res_sat = 1'b0;
    longint m_y       = 0;
    logic   m_sat     = 1'b0;
    logic   m_ov      = 1'b0;
    logic   m_err     = 1'b0;
    int     m_acc_cnt = 0;

    always @(posedge clk) begin
        longint s;
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                m_hist[k] = 0;
                m_h[k]    = 1;
            end
            m_busy = 0;
            m_y    = 0;
            m_sat  = 1'b0;
            m_ov   = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_ov  = 1'b0;
            m_err = 1'b0;
            if (coef_we) begin
                if (m_busy != 0 || int'(coef_addr) >= TAPS) m_err = 1'b1;
                else m_h[int'(coef_addr)] = longint'(coef_data);
            end
            if (m_busy != 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_ov  = 1'b1;
                    m_y   = m_res_y;
                    m_sat = m_res_sat;
                end
            end else if (in_valid) begin
                for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = longint'(x);
                s = 0;
                for (int k = 0; k < TAPS; k++) s += m_h[k] * m_hist[k];
                m_res_sat = (s > YMAX);
                m_res_y   = (s > YMAX) ? YMAX : s;
                m_busy    = TAPS;
                m_acc_cnt++;
            end
        end
    end

    logic [31:0] got_y [$];
    bit          got_s [$];
    int          n_err = 0;
    int          n_b2b = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // One clock: inputs already set by the caller, outputs checked on the falling edge.
    task automatic cycle();
        if (out_valid && in_valid && in_ready) n_b2b++;
        @(posedge clk);
        @(negedge clk);
        check_eq("in_ready", 32'(in_ready), 32'((m_busy == 0) && !reset));
        check_eq("out_valid", 32'(out_valid), 32'(m_ov));
        check_eq("coef_err", 32'(coef_err), 32'(m_err));
        check_eq("y", 32'(y), 32'(m_y));
        check_eq("sat", 32'(sat), 32'(m_sat));
        if (out_valid) begin
            got_y.push_back(32'(y));
            got_s.push_back(sat);
        end
        if (coef_err) n_err++;
    endtask

    task automatic send(input logic [DATA_W-1:0] v);
        int tries = 0;
        x = v;
        in_valid = 1'b1;
        #1;
        while (!in_ready && tries < 50) begin
            cycle();
            tries++;
        end
        if (tries >= 50) check_eq("send_timeout", 32'(0), 32'(1));
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = COEF_W'(d);
        cycle();
        coef_we = 1'b0;
    endtask

    task automatic drain();
        repeat (TAPS + 2) cycle();
    endtask

    task automatic expect_outs(input string tag, input int ey[$], input bit es);
        check_eq({tag, "_count"}, 32'(got_y.size()), 32'(ey.size()));
        for (int i = 0; i < ey.size(); i++) begin
            if (i < got_y.size()) begin
                check_eq(tag, got_y[i], 32'(ey[i]));
                check_eq({tag, "_sat"}, 32'(got_s[i]), 32'(es));
            end
        end
        got_y.delete();
        got_s.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1);
    end

    initial begin
        int exp_q[$];
        int acc0;
        reset = 1'b1; x = '0; in_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        cycle();
        cycle();
        check_eq("reset_y", 32'(y), 32'(0));
        check_eq("reset_ready", 32'(in_ready), 32'(0));
        reset = 1'b0;

        // Moving sum with unity coefficients.
        send(5); send(10); send(15); send(20); send(10);
        drain();
        exp_q = '{5, 15, 30, 50, 55};
        expect_outs("moving_sum", exp_q, 1'b0);

        // Loaded coefficients, impulse response.
        reset = 1'b1; cycle(); reset = 1'b0;
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
        send(1); send(0); send(0); send(0); send(0);
        drain();
        exp_q = '{1, 2, 3, 4, 0};
        expect_outs("impulse", exp_q, 1'b0);

        // Full-scale data and coefficients saturate the 12-bit output.
        for (int k = 0; k < TAPS; k++) wr(k, 255);
        repeat (4) send(255);
        drain();
        exp_q = '{4095, 4095, 4095, 4095};
        expect_outs("saturate", exp_q, 1'b1);

        // in_valid held high: only in_ready cycles accept, back-to-back in out_valid cycle.
        reset = 1'b1; cycle(); reset = 1'b0;
        n_b2b = 0;
        acc0 = m_acc_cnt;
        in_valid = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            x = DATA_W'(i);
            cycle();
        end
        in_valid = 1'b0;
        drain();
        check_eq("stream_accepts", 32'(m_acc_cnt - acc0), 32'(5));
        check_eq("stream_b2b", 32'(n_b2b > 0), 32'(1));
        exp_q = '{1, 7, 18, 34, 54};
        expect_outs("stream", exp_q, 1'b0);

        // Rejected coefficient writes: during MAC and out of range.
        reset = 1'b1; cycle(); reset = 1'b0;
        wr(0, 3); wr(1, 1); wr(2, 4); wr(3, 1);
        n_err = 0;
        send(2);
        wr(0, 99);
        drain();
        wr(5, 9);
        send(5);
        drain();
        check_eq("coef_err_pulses", 32'(n_err), 32'(2));
        exp_q = '{6, 17};
        expect_outs("coef_reject", exp_q, 1'b0);

        // Reset two cycles into MAC aborts the result.
        send(9);
        cycle();
        cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        drain();
        check_eq("abort_no_output", 32'(got_y.size()), 32'(0));
        check_eq("abort_y", 32'(y), 32'(0));
        send(7);
        drain();
        exp_q = '{7};
        expect_outs("after_abort", exp_q, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            x         = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 15));
            coef_we   = ($urandom_range(0, 5) == 0);
            coef_addr = AW'($urandom);
            coef_data = ($urandom_range(0, 1) == 1) ? COEF_W'($urandom) : COEF_W'($urandom_range(0, 3));
            reset     = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
